lr_matrix_sched: RTL and testbench
==================================

LR_MATRIX_SCHED -- requirements
Module: lr_matrix_sched

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of all signed sample ports.
REQ-002 SHALL have parameter CNT_WIDTH, default 16, width of completed-pair counter.
REQ-003 SHALL have port clock  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports sum_rd_en output 1, sum_empty input 1, sum_dout input DATA_WIDTH signed: L+R input FIFO read side.
REQ-006 SHALL have ports dif_rd_en output 1, dif_empty input 1, dif_dout input DATA_WIDTH signed: L-R input FIFO read side.
REQ-007 SHALL have ports left_wr_en output 1, left_full input 1, left_din output DATA_WIDTH signed: left output FIFO write side.
REQ-008 SHALL have ports right_wr_en output 1, right_full input 1, right_din output DATA_WIDTH signed: right output FIFO write side.
REQ-009 SHALL have port stereo_en  input  1  1 = stereo matrix, 0 = mono (L = R = sum).
REQ-010 SHALL have port pair_cnt  output  CNT_WIDTH  count of completed output pairs.
REQ-011 SHALL have port busy  output  1  high whenever state is not S_IDLE.

Function
REQ-012 SHALL use one shared add/sub unit, time-multiplexed, with states S_IDLE, S_LEFT, S_RIGHT, S_WRITE.
REQ-013 S_IDLE: when !sum_empty && !dif_empty, SHALL pulse sum_rd_en and dif_rd_en together for one cycle, latch sum_dout, dif_dout and stereo_en into registers, then go to S_LEFT; otherwise SHALL stay and assert no rd_en.
REQ-014 SHALL never read only one input FIFO; if exactly one FIFO is empty, neither rd_en asserts.
REQ-015 S_LEFT: SHALL register left = sum + dif (stereo) or sum (mono), then go to S_RIGHT unconditionally.
REQ-016 S_RIGHT: SHALL register right = sum - dif (stereo) or sum (mono), then go to S_WRITE unconditionally.
REQ-017 S_WRITE: only when !left_full && !right_full, SHALL pulse left_wr_en and right_wr_en together for one cycle with registered results on left_din/right_din, increment pair_cnt, and go to S_IDLE; otherwise SHALL hold all state.
REQ-018 left_din/right_din SHALL be 0 in every cycle in which the corresponding wr_en is low.
REQ-019 Arithmetic SHALL be two's-complement modulo 2^DATA_WIDTH: wrap, no saturation, no scaling.
REQ-020 Latency: with outputs not full, writes SHALL occur exactly 3 cycles after the read cycle; peak throughput one pair per 4 cycles.
REQ-021 pair_cnt SHALL wrap from 2^CNT_WIDTH-1 to 0.
REQ-022 stereo_en changes SHALL affect only pairs read after the change; an in-flight pair uses its latched mode.
REQ-023 Unreachable state encodings SHALL return to S_IDLE with no rd_en/wr_en asserted.

Reset
REQ-024 On reset_n low, SHALL immediately force state S_IDLE, all data registers 0, latched mode 0, pair_cnt 0.
REQ-025 During reset, all rd_en/wr_en SHALL be 0, left_din/right_din 0, busy 0; an in-flight pair SHALL be discarded, not written.
REQ-026 After reset_n rises, SHALL first sample input FIFO status on the next rising edge.

Structure
REQ-027 State enum type and default width constants SHALL reside in the shared global package.
REQ-028 Shared datapath SHALL be one sub-module addsub_unit (inputs a, b, op_sub, mono; combinational output), instanced once.

Verification
REQ-029 Stereo: sum=100, dif=30, stereo_en=1, outputs free -> reads at T, left=130 and right=70 written together at T+3, pair_cnt=1.
REQ-030 Mono: sum=-5, dif=99, stereo_en=0 -> left=-5, right=-5, one write pulse.
REQ-031 Wrap: sum=32'h7FFFFFFF, dif=1 -> left=32'h80000000, right=32'h7FFFFFFE.
REQ-032 Backpressure: right_full=1 for 5 cycles in S_WRITE -> no wr_en, outputs held, no new rd_en; single write when right_full clears.
REQ-033 Single empty: sum non-empty, dif_empty=1 for 10 cycles -> no rd_en on either FIFO, busy=0.
REQ-034 Reset mid-pair: reset_n low in S_RIGHT -> no write, pair_cnt=0, next pair processed normally after release.

Source files
------------

// File: rtl/lr_matrix_sched_pkg.sv
// Shared definitions for the L/R matrix scheduler.
// This file holds the FSM state type and the default widths used by the top and its datapath.
package lr_matrix_sched_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_CNT_WIDTH  = 16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LEFT  = 2'd1,
    S_RIGHT = 2'd2,
    S_WRITE = 2'd3
  } state_e;

endpackage

// File: rtl/lr_matrix_sched_addsub.sv
// Shared add/subtract unit, time-multiplexed between the left and right results.
// In mono mode it passes operand a through unchanged.
module addsub_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic signed [DATA_WIDTH-1:0] a,
  input  logic signed [DATA_WIDTH-1:0] b,
  input  logic                         op_sub,
  input  logic                         mono,
  output logic signed [DATA_WIDTH-1:0] result
);

  // Two's-complement wrap is intended; no saturation or scaling is applied.
  always_comb begin
    if (mono) begin
      result = a;
    end else if (op_sub) begin
      result = a - b;
    end else begin
      result = a + b;
    end
  end

endmodule

// File: rtl/lr_matrix_sched.sv
// Converts (L+R, L-R) sample pairs into (L, R) pairs using one shared add/sub unit.
// Each pair is read from both input FIFOs together and written to both output FIFOs together.
module lr_matrix_sched
  import lr_matrix_sched_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                         clock,
  input  logic                         reset_n,
  output logic                         sum_rd_en,
  input  logic                         sum_empty,
  input  logic signed [DATA_WIDTH-1:0] sum_dout,
  output logic                         dif_rd_en,
  input  logic                         dif_empty,
  input  logic signed [DATA_WIDTH-1:0] dif_dout,
  output logic                         left_wr_en,
  input  logic                         left_full,
  output logic signed [DATA_WIDTH-1:0] left_din,
  output logic                         right_wr_en,
  input  logic                         right_full,
  output logic signed [DATA_WIDTH-1:0] right_din,
  input  logic                         stereo_en,
  output logic [CNT_WIDTH-1:0]         pair_cnt,
  output logic                         busy
);

  state_e                       state_q, state_d;
  logic signed [DATA_WIDTH-1:0] sum_q, sum_d;
  logic signed [DATA_WIDTH-1:0] dif_q, dif_d;
  logic signed [DATA_WIDTH-1:0] left_q, left_d;
  logic signed [DATA_WIDTH-1:0] right_q, right_d;
  logic                         mode_q, mode_d;
  logic [CNT_WIDTH-1:0]         cnt_q, cnt_d;
  logic                         rd_fire;
  logic                         wr_fire;
  logic signed [DATA_WIDTH-1:0] alu_result;

  // Strobes are gated by reset_n so nothing is read or written while reset is held.
  assign rd_fire = reset_n && (state_q == S_IDLE) && !sum_empty && !dif_empty;
  assign wr_fire = reset_n && (state_q == S_WRITE) && !left_full && !right_full;

  addsub_unit #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_addsub (
    .a      (sum_q),
    .b      (dif_q),
    .op_sub (state_q == S_RIGHT),
    .mono   (!mode_q),
    .result (alu_result)
  );

  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    dif_d   = dif_q;
    left_d  = left_q;
    right_d = right_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (rd_fire) begin
          sum_d   = sum_dout;
          dif_d   = dif_dout;
          mode_d  = stereo_en;
          state_d = S_LEFT;
        end
      end
      S_LEFT: begin
        left_d  = alu_result;
        state_d = S_RIGHT;
      end
      S_RIGHT: begin
        right_d = alu_result;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        if (wr_fire) begin
          cnt_d   = cnt_q + CNT_WIDTH'(1);
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      sum_q   <= '0;
      dif_q   <= '0;
      left_q  <= '0;
      right_q <= '0;
      mode_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      dif_q   <= dif_d;
      left_q  <= left_d;
      right_q <= right_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
    end
  end

  assign sum_rd_en   = rd_fire;
  assign dif_rd_en   = rd_fire;
  assign left_wr_en  = wr_fire;
  assign right_wr_en = wr_fire;
  assign left_din    = wr_fire ? left_q : '0;
  assign right_din   = wr_fire ? right_q : '0;
  assign pair_cnt    = cnt_q;
  assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_lr_matrix_sched.sv
// Bench for lr_matrix_sched: queue-backed input FIFOs, a pair-level behavioural model
// compared every cycle, and directed scenarios pinned with hand-computed literals.
module tb_lr_matrix_sched;

  localparam int DW = 32;
  localparam int CW = 4;

  logic                 clock = 1'b0;
  logic                 reset_n;
  logic                 sum_rd_en, sum_empty;
  logic signed [DW-1:0] sum_dout;
  logic                 dif_rd_en, dif_empty;
  logic signed [DW-1:0] dif_dout;
  logic                 left_wr_en, left_full;
  logic signed [DW-1:0] left_din;
  logic                 right_wr_en, right_full;
  logic signed [DW-1:0] right_din;
  logic                 stereo_en;
  logic [CW-1:0]        pair_cnt;
  logic                 busy;

  always #5 clock = ~clock;

  lr_matrix_sched #(
    .DATA_WIDTH(DW),
    .CNT_WIDTH (CW)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .sum_rd_en   (sum_rd_en),
    .sum_empty   (sum_empty),
    .sum_dout    (sum_dout),
    .dif_rd_en   (dif_rd_en),
    .dif_empty   (dif_empty),
    .dif_dout    (dif_dout),
    .left_wr_en  (left_wr_en),
    .left_full   (left_full),
    .left_din    (left_din),
    .right_wr_en (right_wr_en),
    .right_full  (right_full),
    .right_din   (right_din),
    .stereo_en   (stereo_en),
    .pair_cnt    (pair_cnt),
    .busy        (busy)
  );

  logic signed [DW-1:0] sumQ[$];
  logic signed [DW-1:0] difQ[$];
  int total = 0;
  int bad = 0;
  int cycle = 0;
  int rdCount = 0;
  int wrCount = 0;
  int lastRdCycle = 0;
  int lastWrCycle = 0;
  int prevWrCycle = 0;
  logic signed [DW-1:0] lastL = '0;
  logic signed [DW-1:0] lastR = '0;
  bit popS, popD;

  // Pair-level model: at most one pair in flight, written no earlier than 3 cycles after its read.
  bit                   mInflight = 1'b0;
  int                   mAge = 0;
  logic signed [DW-1:0] mL = '0;
  logic signed [DW-1:0] mR = '0;
  logic [CW-1:0]        mCnt = '0;
  bit                   expRd = 1'b0;
  bit                   expWr = 1'b0;
  logic signed [DW-1:0] hSum, hDif;
  bit                   hStereo;

  task automatic check(string nm, logic [DW-1:0] act, logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at cycle %0d", nm, act, exp, cycle);
    end
  endtask

  function automatic void refreshHeads();
    sum_empty = (sumQ.size() == 0);
    dif_empty = (difQ.size() == 0);
    sum_dout  = sum_empty ? '0 : sumQ[0];
    dif_dout  = dif_empty ? '0 : difQ[0];
  endfunction

  always @(posedge clock) begin
    popS = sum_rd_en;
    popD = dif_rd_en;
    #1;
    if (popS && sumQ.size() > 0) void'(sumQ.pop_front());
    if (popD && difQ.size() > 0) void'(difQ.pop_front());
    refreshHeads();
  end

  always @(posedge clock) begin
    if (!reset_n) begin
      mInflight = 1'b0;
      mAge      = 0;
      mCnt      = '0;
    end else if (expRd) begin
      mInflight = 1'b1;
      mAge      = 1;
      mL        = hStereo ? hSum + hDif : hSum;
      mR        = hStereo ? hSum - hDif : hSum;
    end else if (mInflight) begin
      if (expWr) begin
        mInflight = 1'b0;
        mCnt      = mCnt + 1'b1;
      end else begin
        mAge++;
      end
    end
  end

  always @(negedge clock) begin
    cycle++;
    if (!reset_n) begin
      expRd = 1'b0;
      expWr = 1'b0;
    end else begin
      expRd = !mInflight && !sum_empty && !dif_empty;
      expWr = mInflight && (mAge >= 3) && !left_full && !right_full;
    end
    hSum    = sum_dout;
    hDif    = dif_dout;
    hStereo = stereo_en;
    check("sum_rd_en", sum_rd_en, expRd);
    check("dif_rd_en", dif_rd_en, expRd);
    check("left_wr_en", left_wr_en, expWr);
    check("right_wr_en", right_wr_en, expWr);
    check("left_din", left_din, expWr ? mL : '0);
    check("right_din", right_din, expWr ? mR : '0);
    check("busy", busy, reset_n && mInflight);
    check("pair_cnt", pair_cnt, reset_n ? mCnt : '0);
    if (sum_rd_en) begin
      rdCount++;
      lastRdCycle = cycle;
    end
    if (left_wr_en) begin
      wrCount++;
      prevWrCycle = lastWrCycle;
      lastWrCycle = cycle;
      lastL = left_din;
      lastR = right_din;
    end
  end

  task automatic step(int n = 1);
    repeat (n) begin
      @(posedge clock);
      #2;
    end
  endtask

  task automatic pushPair(input logic signed [DW-1:0] s, input logic signed [DW-1:0] d);
    sumQ.push_back(s);
    difQ.push_back(d);
    refreshHeads();
  endtask

  task automatic waitWrites(int target, int budget);
    int k = 0;
    while (wrCount < target && k < budget) begin
      step();
      k++;
    end
    total++;
    if (wrCount < target) begin
      bad++;
      $display("[TB] FAIL wait_write: got %0d writes expected %0d", wrCount, target);
    end
  endtask

  task automatic waitReads(int target, int budget);
    int k = 0;
    while (rdCount < target && k < budget) begin
      step();
      k++;
    end
    total++;
    if (rdCount < target) begin
      bad++;
      $display("[TB] FAIL wait_read: got %0d reads expected %0d", rdCount, target);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset_n    = 1'b1;
    stereo_en  = 1'b1;
    left_full  = 1'b0;
    right_full = 1'b0;
    refreshHeads();
    #1 reset_n = 1'b0;
    step(2);

    // A pair waiting during reset must not be read until release.
    pushPair(100, 30);
    step(2);
    check("reset_busy", busy, 1'b0);
    check("reset_cnt", pair_cnt, '0);
    check("reset_no_read", rdCount, 0);
    reset_n = 1'b1;
    waitWrites(1, 20);
    check("stereo_left", lastL, 32'd130);
    check("stereo_right", lastR, 32'd70);
    check("stereo_latency", lastWrCycle - lastRdCycle, 3);
    check("stereo_cnt", pair_cnt, 4'd1);

    stereo_en = 1'b0;
    pushPair(-5, 99);
    waitWrites(2, 20);
    check("mono_left", lastL, 32'hFFFF_FFFB);
    check("mono_right", lastR, 32'hFFFF_FFFB);
    check("mono_latency", lastWrCycle - lastRdCycle, 3);
    check("mono_cnt", pair_cnt, 4'd2);

    stereo_en = 1'b1;
    pushPair(32'h7FFF_FFFF, 1);
    waitWrites(3, 20);
    check("wrap_left", lastL, 32'h8000_0000);
    check("wrap_right", lastR, 32'h7FFF_FFFE);

    // Right output full for five cycles while the pair sits ready to write.
    right_full = 1'b1;
    pushPair(10, 4);
    pushPair(20, 5);
    waitReads(4, 20);
    step(2);
    step(5);
    check("bp_no_write", wrCount, 3);
    check("bp_no_read", rdCount, 4);
    check("bp_busy", busy, 1'b1);
    right_full = 1'b0;
    waitWrites(4, 10);
    check("bp_single_write", wrCount, 4);
    check("bp_left", lastL, 32'd14);
    check("bp_right", lastR, 32'd6);
    waitWrites(5, 20);
    check("bp_next_left", lastL, 32'd25);
    check("bp_next_right", lastR, 32'd15);

    sumQ.push_back(7);
    refreshHeads();
    step(10);
    check("single_empty_no_read", rdCount, 5);
    check("single_empty_busy", busy, 1'b0);
    difQ.push_back(3);
    refreshHeads();
    waitWrites(6, 20);
    check("single_empty_left", lastL, 32'd10);
    check("single_empty_right", lastR, 32'd4);

    // Reset while the pair is in the right-result step.
    pushPair(50, 8);
    waitReads(7, 20);
    step(1);
    check("midreset_busy_before", busy, 1'b1);
    reset_n = 1'b0;
    #1;
    check("midreset_busy", busy, 1'b0);
    check("midreset_cnt", pair_cnt, '0);
    step(2);
    reset_n = 1'b1;
    step(6);
    check("midreset_discard", wrCount, 6);
    check("midreset_cnt_after", pair_cnt, '0);
    pushPair(1, 2);
    waitWrites(7, 20);
    check("after_reset_left", lastL, 32'd3);
    check("after_reset_right", lastR, 32'hFFFF_FFFF);
    check("after_reset_cnt", pair_cnt, 4'd1);

    pushPair(40, 15);
    waitReads(9, 20);
    stereo_en = 1'b0;
    waitWrites(8, 20);
    check("latched_mode_left", lastL, 32'd55);
    check("latched_mode_right", lastR, 32'd25);
    pushPair(40, 15);
    waitWrites(9, 20);
    check("new_mode_left", lastL, 32'd40);
    check("new_mode_right", lastR, 32'd40);

    stereo_en = 1'b1;
    left_full = 1'b1;
    pushPair(-3, -4);
    step(8);
    check("left_full_hold", wrCount, 9);
    left_full = 1'b0;
    waitWrites(10, 10);
    check("left_full_left", lastL, 32'hFFFF_FFF9);
    check("left_full_right", lastR, 32'd1);
    check("left_full_cnt", pair_cnt, 4'd4);

    // Back-to-back burst: one pair per 4 cycles, counter wraps past 15.
    for (int i = 0; i < 18; i++) pushPair(i * 3, i);
    waitWrites(28, 120);
    check("burst_left", lastL, 32'd68);
    check("burst_right", lastR, 32'd34);
    check("burst_gap", lastWrCycle - prevWrCycle, 4);
    check("burst_cnt_wrap", pair_cnt, 4'd6);

    step(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
